rx_frame_deserializer: RTL and testbench
========================================

# rx_frame_deserializer

Parametrised UART receive deserializer that assembles a variable-length data field from a stream of sampled bits, with run-time selectable bit order, an internal bit counter and a registered frame output with a one-cycle valid strobe. It sits in the UART RX path between the bit-sampling logic, which supplies one strobed bit per bit period, and the parity-check/stop-check and FSM logic. It replaces the free-running shift register with a self-terminating frame assembler.

## Interface
- MAX_DATA_WIDTH, 8, maximum data bits per frame (≥2); sizes o_data
- LEN_W, $clog2(MAX_DATA_WIDTH+1), width of i_data_len (derived, not overridden)
- i_clk  input  1  clock
- i_rst_n  input  1  reset; asynchronous, active-low
- i_start  input  1  one-cycle pulse: start bit accepted, arm a new frame
- i_abort  input  1  one-cycle pulse: discard frame in progress (framing error, line break)
- i_sample_valid  input  1  one-cycle strobe: i_sampled_bit is valid this cycle
- i_sampled_bit  input  1  sampled serial data bit
- i_data_len  input  LEN_W  data bits per frame, latched on i_start
- i_msb_first  input  1  0 = LSB first (UART standard), 1 = MSB first; latched on i_start
- o_data  output  MAX_DATA_WIDTH  last completed frame, right-aligned, unused upper bits 0
- o_data_valid  output  1  one-cycle pulse: o_data updated
- o_busy  output  1  high while a frame is being assembled
- o_bit_count  output  LEN_W  data bits received in current frame

## Operation
- Two states: IDLE, SHIFT. Reset → IDLE.
- IDLE: i_start → latch len and order, clear shift register and counter, go SHIFT. i_sample_valid and i_abort ignored.
- Length clamp at latch: i_data_len = 0 or > MAX_DATA_WIDTH → MAX_DATA_WIDTH.
- SHIFT, i_sample_valid: LSB-first writes the bit at shift[count]; MSB-first does shift ← {shift[MAX-2:0], bit}. count increments.
- Both orders leave the result right-aligned in bits [len-1:0], with upper bits 0.
- Sample taking count to len: o_data ← assembled value (including this bit), o_data_valid ← 1 for one cycle, counter cleared, → IDLE.
- SHIFT, i_abort: → IDLE, counter cleared, o_data unchanged, no valid.
- SHIFT, i_start (without abort): restart. Re-latch len/order, clear shift and counter, stay SHIFT, partial frame discarded, no valid. A coincident i_sample_valid is dropped.
- Priority within one cycle: i_abort > i_start > i_sample_valid.
- o_busy = (state == SHIFT). o_bit_count = internal counter.
- i_data_len/i_msb_first changes during SHIFT have no effect on the current frame.

## Timing
- Reset values: o_data = 0, o_data_valid = 0, o_busy = 0, o_bit_count = 0, state IDLE, shift register 0.
- Async assert takes effect immediately, including mid-frame. The frame is lost; deassertion returns to IDLE with no valid.
- i_start at edge N: o_busy = 1 from N+1, o_bit_count = 0.
- Each sample at edge N: o_bit_count increments at N+1.
- Last sample at edge N: o_data and o_data_valid update at N+1; o_busy = 0 at N+1. o_data_valid low again at N+2.
- Latency: final bit to valid data is 1 cycle.
- Back-to-back frames: i_start is legal at N+1, the same cycle o_data_valid is high.
- o_data holds until the next completed frame or reset.

## Test plan
- Reset, i_start, len=8, LSB-first, bits 1,0,1,0,0,1,0,1 → o_data = 0xA5, o_data_valid high exactly one cycle, 1 cycle after the 8th strobe, o_busy falls together with it.
- len=5, MSB-first, bits 1,0,1,1,0 → o_data = 0x16, bits [7:5] = 0. Same bits LSB-first → 0x0D.
- len=8 frame, 4 bits received then i_abort → no valid, o_data keeps the previous value (0xA5), o_busy = 0, o_bit_count = 0.
- i_data_len = 0 and i_data_len = 15 → frame completes after 8 strobes. i_start after 3 bits → counter restarts, frame completes 8 strobes after the second start.
- Simultaneous i_abort + i_start + i_sample_valid in SHIFT → IDLE, no capture. i_start + i_sample_valid in IDLE → SHIFT with o_bit_count = 0.
- Assert i_rst_n low after the 6th bit of an 8-bit frame → all outputs 0 immediately. After release, 2 strobes without i_start → no change; a full frame 0x3C then completes normally.

Source files
------------

// File: rtl/rx_frame_deserializer_if.sv
// Handshake bundle between the bit sampler (master) and the frame deserializer (slave).
// Carries the per-bit strobes in and the assembled frame out.
interface rx_frame_deserializer_if #(
  parameter int MAX_DATA_WIDTH = 8
);
  localparam int LEN_W = $clog2(MAX_DATA_WIDTH + 1);

  logic                      i_start;
  logic                      i_abort;
  logic                      i_sample_valid;
  logic                      i_sampled_bit;
  logic [LEN_W-1:0]          i_data_len;
  logic                      i_msb_first;
  logic [MAX_DATA_WIDTH-1:0] o_data;
  logic                      o_data_valid;
  logic                      o_busy;
  logic [LEN_W-1:0]          o_bit_count;

  modport master (
    output i_start, i_abort, i_sample_valid, i_sampled_bit, i_data_len, i_msb_first,
    input  o_data, o_data_valid, o_busy, o_bit_count
  );

  modport slave (
    input  i_start, i_abort, i_sample_valid, i_sampled_bit, i_data_len, i_msb_first,
    output o_data, o_data_valid, o_busy, o_bit_count
  );
endinterface

// File: rtl/rx_frame_deserializer.sv
// Self-terminating UART RX frame assembler: collects a latched number of sampled bits
// in either bit order and presents the right-aligned result with a one-cycle strobe.
module rx_frame_deserializer #(
  parameter int MAX_DATA_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  rx_frame_deserializer_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_DATA_WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                    r_state, w_state_nxt;
  logic [LEN_W-1:0]          r_len, w_len_nxt;
  logic [LEN_W-1:0]          r_count, w_count_nxt, w_count_inc;
  logic                      r_msb, w_msb_nxt;
  logic [MAX_DATA_WIDTH-1:0] r_shift, w_shift_nxt, w_assembled;
  logic [MAX_DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                      r_valid, w_valid_nxt;

  // Zero or oversize lengths fall back to the full data width.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0 || int'(len) > MAX_DATA_WIDTH) return LEN_W'(MAX_DATA_WIDTH);
    return len;
  endfunction

  assign w_count_inc = r_count + 1'b1;

  // Shift register value including the bit arriving this cycle.
  always_comb begin
    w_assembled = r_shift;
    if (r_msb) begin
      w_assembled = {r_shift[MAX_DATA_WIDTH-2:0], bus.i_sampled_bit};
    end else begin
      for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
        if (LEN_W'(i) == r_count) w_assembled[i] = bus.i_sampled_bit;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_msb_nxt   = r_msb;
    w_count_nxt = r_count;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_state_nxt = SHIFT;
          w_len_nxt   = clamp_len(bus.i_data_len);
          w_msb_nxt   = bus.i_msb_first;
          w_count_nxt = '0;
          w_shift_nxt = '0;
        end
      end
      SHIFT: begin
        if (bus.i_abort) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else if (bus.i_start) begin
          w_len_nxt   = clamp_len(bus.i_data_len);
          w_msb_nxt   = bus.i_msb_first;
          w_count_nxt = '0;
          w_shift_nxt = '0;
        end else if (bus.i_sample_valid) begin
          if (w_count_inc == r_len) begin
            w_state_nxt = IDLE;
            w_data_nxt  = w_assembled;
            w_valid_nxt = 1'b1;
            w_count_nxt = '0;
            w_shift_nxt = '0;
          end else begin
            w_shift_nxt = w_assembled;
            w_count_nxt = w_count_inc;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_msb   <= 1'b0;
      r_count <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_msb   <= w_msb_nxt;
      r_count <= w_count_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign bus.o_data       = r_data;
  assign bus.o_data_valid = r_valid;
  assign bus.o_busy       = (r_state == SHIFT);
  assign bus.o_bit_count  = r_count;
endmodule

// File: tb/tb_rx_frame_deserializer.sv
// Bench for rx_frame_deserializer: directed frames plus random traffic, all checked
// cycle by cycle against a bit-list reference model.
module tb_rx_frame_deserializer;
  localparam int MAXW  = 8;
  localparam int LEN_W = $clog2(MAXW + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rx_frame_deserializer_if #(.MAX_DATA_WIDTH(MAXW)) bus ();

  rx_frame_deserializer #(.MAX_DATA_WIDTH(MAXW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: frame kept as a list of received bits.
  logic            m_busy;
  int              m_len;
  logic            m_msb;
  int              m_bits[$];
  logic [MAXW-1:0] m_data;
  logic            m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_len = 0; m_msb = 1'b0; m_bits.delete(); m_data = '0; m_valid = 1'b0;
  endtask

  function automatic int eff_len(input logic [LEN_W-1:0] len);
    if (len == 0 || int'(len) > MAXW) return MAXW;
    return int'(len);
  endfunction

  task automatic model_step(input logic st, ab, sv, b, input logic [LEN_W-1:0] len, input logic msb);
    logic [MAXW-1:0] val;
    m_valid = 1'b0;
    if (!m_busy) begin
      if (st) begin
        m_busy = 1'b1; m_len = eff_len(len); m_msb = msb; m_bits.delete();
      end
    end else if (ab) begin
      m_busy = 1'b0; m_bits.delete();
    end else if (st) begin
      m_len = eff_len(len); m_msb = msb; m_bits.delete();
    end else if (sv) begin
      m_bits.push_back(int'(b));
      if (m_bits.size() == m_len) begin
        val = '0;
        for (int i = 0; i < m_len; i++) begin
          if (m_bits[i] != 0) begin
            if (m_msb) val[m_len-1-i] = 1'b1;
            else       val[i] = 1'b1;
          end
        end
        m_data = val; m_valid = 1'b1; m_busy = 1'b0; m_bits.delete();
      end
    end
  endtask

  task automatic compare_all();
    chk("data",  32'(bus.o_data),       32'(m_data));
    chk("valid", 32'(bus.o_data_valid), 32'(m_valid));
    chk("busy",  32'(bus.o_busy),       32'(m_busy));
    chk("count", 32'(bus.o_bit_count),  32'(m_bits.size()));
  endtask

  // One clock: drive inputs, advance model, sample just after the edge.
  task automatic cyc(input logic st, ab, sv, b, input logic [LEN_W-1:0] len, input logic msb);
    bus.i_start = st; bus.i_abort = ab; bus.i_sample_valid = sv;
    bus.i_sampled_bit = b; bus.i_data_len = len; bus.i_msb_first = msb;
    model_step(st, ab, sv, b, len, msb);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, LEN_W'(0), 1'b0);
  endtask

  // seq[i] is the i-th transmitted bit.
  task automatic send_bits(input logic [15:0] seq, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, seq[i], LEN_W'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
  endtask

  task automatic start(input logic [LEN_W-1:0] len, input logic msb);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, len, msb);
  endtask

  initial begin
    bus.i_start = 0; bus.i_abort = 0; bus.i_sample_valid = 0;
    bus.i_sampled_bit = 0; bus.i_data_len = '0; bus.i_msb_first = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(bus.o_data), 32'h0);
    chk("rst_busy", 32'(bus.o_busy), 32'h0);
    chk("rst_cnt",  32'(bus.o_bit_count), 32'h0);
    chk("rst_vld",  32'(bus.o_data_valid), 32'h0);
    #3 rst_n = 1'b1;

    // 0xA5 LSB first
    start(LEN_W'(8), 1'b0);
    chk("start_busy", 32'(bus.o_busy), 32'h1);
    send_bits(16'h00A5, 8);
    chk("a5_data", 32'(bus.o_data), 32'hA5);
    chk("a5_vld",  32'(bus.o_data_valid), 32'h1);
    chk("a5_busy", 32'(bus.o_busy), 32'h0);
    idle_cyc();
    chk("a5_vld_low", 32'(bus.o_data_valid), 32'h0);

    // Abort after 4 bits keeps previous data
    start(LEN_W'(8), 1'b0);
    send_bits(16'h000F, 4);
    chk("pre_abort_cnt", 32'(bus.o_bit_count), 32'h4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, LEN_W'(8), 1'b0);
    chk("abort_data", 32'(bus.o_data), 32'hA5);
    chk("abort_busy", 32'(bus.o_busy), 32'h0);
    chk("abort_cnt",  32'(bus.o_bit_count), 32'h0);

    // len 5, bits 1,0,1,1,0 both orders
    start(LEN_W'(5), 1'b1);
    send_bits(16'h000D, 5);
    chk("msb5_data", 32'(bus.o_data), 32'h16);
    start(LEN_W'(5), 1'b0);
    send_bits(16'h000D, 5);
    chk("lsb5_data", 32'(bus.o_data), 32'h0D);

    // Length clamp: 0 and 15 both mean 8
    start(LEN_W'(0), 1'b0);
    send_bits(16'h0081, 7);
    chk("len0_no_vld", 32'(bus.o_data_valid), 32'h0);
    send_bits(16'h0001, 1);
    chk("len0_vld", 32'(bus.o_data_valid), 32'h1);
    chk("len0_data", 32'(bus.o_data), 32'h81);
    start(LEN_W'(15), 1'b1);
    send_bits(16'h00F0, 8);
    chk("len15_vld", 32'(bus.o_data_valid), 32'h1);
    chk("len15_data", 32'(bus.o_data), 32'h0F);

    // Restart after 3 bits
    start(LEN_W'(8), 1'b0);
    send_bits(16'h0007, 3);
    start(LEN_W'(8), 1'b0);
    chk("restart_cnt", 32'(bus.o_bit_count), 32'h0);
    send_bits(16'h0055, 8);
    chk("restart_data", 32'(bus.o_data), 32'h55);

    // abort+start+sample in SHIFT, then start+sample in IDLE
    start(LEN_W'(8), 1'b0);
    send_bits(16'h0003, 2);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, LEN_W'(8), 1'b0);
    chk("triple_busy", 32'(bus.o_busy), 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, LEN_W'(8), 1'b0);
    chk("idle_start_busy", 32'(bus.o_busy), 32'h1);
    chk("idle_start_cnt",  32'(bus.o_bit_count), 32'h0);

    // Async reset mid-frame
    start(LEN_W'(8), 1'b0);
    send_bits(16'h003F, 6);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_data", 32'(bus.o_data), 32'h0);
    chk("arst_busy", 32'(bus.o_busy), 32'h0);
    chk("arst_cnt",  32'(bus.o_bit_count), 32'h0);
    #2 rst_n = 1'b1;
    send_bits(16'h0003, 2);
    chk("post_rst_data", 32'(bus.o_data), 32'h0);
    start(LEN_W'(8), 1'b0);
    send_bits(16'h003C, 8);
    chk("3c_data", 32'(bus.o_data), 32'h3C);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 1) == 1, LEN_W'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
